even_parity_rx: RTL

Serial receiver that checks even parity on incoming frames. It is the receive end of the even-parity link, whose transmitter appends one bit making the total count of ones in data plus parity even. It deserialises a start/data/parity/stop frame, presents the data word, and flags parity and framing errors. It also keeps a saturating count of parity errors for status readback.

---
 rtl/even_parity_rx_if.sv | 18 +
 rtl/even_parity_rx.sv | 85 ++++++++
 2 files changed

// File: rtl/even_parity_rx_if.sv
// even_parity_rx_if: serial line, status and counter signals of the even-parity receiver.
interface even_parity_rx_if #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
);
   logic              rx_in;
   logic              clr_count;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;
   logic [CNT_W-1:0]  err_count;
   modport master (output rx_in, clr_count,
                   input  data_out, data_valid, parity_err, frame_err, busy, err_count);
   modport slave  (input  rx_in, clr_count,
                   output data_out, data_valid, parity_err, frame_err, busy, err_count);
endinterface

// File: rtl/even_parity_rx.sv
// even_parity_rx: deserialises start/data/parity/stop frames, flags parity and framing
// errors and keeps a saturating parity-error count.
module even_parity_rx #(
   parameter int DATA_W     = 4,
   parameter int BIT_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input logic              clk,
   input logic              rst,
   even_parity_rx_if.slave  bus
);
   localparam int HALF = BIT_CYCLES / 2;
   localparam int CW   = $clog2(BIT_CYCLES);
   localparam int IW   = $clog2(DATA_W);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic [DATA_W-1:0] r_shift, r_data;
   logic [CNT_W-1:0]  r_err_cnt;
   logic              r_armed, r_par, r_perr, r_ferr;
   logic              w_half, w_tick, w_last, w_wrap;
   assign w_half = r_cnt == CW'(HALF - 1);
   assign w_tick = r_cnt == CW'(BIT_CYCLES - 1);
   assign w_last = r_idx == IW'(DATA_W - 1);
   assign w_wrap = (r_state == START) ? w_half : w_tick;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (r_armed && !bus.rx_in) ? START : IDLE;
         START:   w_next = !w_half ? START : (bus.rx_in ? IDLE : DATA);
         DATA:    w_next = (w_tick && w_last) ? PARITY : DATA;
         PARITY:  w_next = w_tick ? STOP : PARITY;
         STOP:    w_next = w_tick ? DONE : STOP;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      bus.busy       = r_state != IDLE;
      bus.data_valid = r_state == DONE;
   end
   // Outputs are captured at the stop sample so they are already valid during DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_armed   <= 1'b0;
         r_par     <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_cnt <= (r_state == IDLE || r_state == DONE || w_wrap) ? '0 : r_cnt + 1'b1;
         if (r_state == IDLE) begin
            r_idx <= '0;
            if (bus.rx_in) r_armed <= 1'b1;
         end
         if (r_state == DATA && w_tick) begin
            r_shift[r_idx] <= bus.rx_in;
            r_idx          <= w_last ? '0 : r_idx + 1'b1;
         end
         if (r_state == PARITY && w_tick) r_par <= bus.rx_in;
         if (r_state == STOP && w_tick) begin
            r_data  <= r_shift;
            r_perr  <= ^r_shift ^ r_par;
            r_ferr  <= ~bus.rx_in;
            r_armed <= bus.rx_in;
         end
         if (bus.clr_count)
            r_err_cnt <= '0;
         else if (r_state == DONE && r_perr && r_err_cnt != '1)
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end
   assign bus.data_out   = r_data;
   assign bus.parity_err = r_perr;
   assign bus.frame_err  = r_ferr;
   assign bus.err_count  = r_err_cnt;
endmodule
